// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared types and helpers for the RAM burst master.
//   state_t      - burst FSM state encoding (exposed on the master's o_state)
//   OP_READ/WRITE - values of i_cmd_write and of the RAM write enable
//   clog2_depth  - bits needed to hold the values 0..value (minimum 1)
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Counters must represent their full value (e.g. a FIFO count of DEPTH),
  // so this is the width of 0..value rather than a plain ceil(log2).
  function automatic int clog2_depth(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_burst_fifo.sv
// ram_burst_fifo: synchronous FIFO holding read beats returned by the RAM.
//   i_clk, i_rst_n - clock, synchronous active-low reset (clears contents)
//   i_push, i_din  - write one entry (ignored when full)
//   i_pop          - remove the head entry (ignored when empty)
//   o_dout         - head entry, forced to 0 while empty
//   o_count        - number of stored entries, 0..FIFO_DEPTH
//   o_empty/o_full - occupancy flags
module ram_burst_fifo
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = clog2_depth(FIFO_DEPTH),
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(FIFO_DEPTH));
  assign o_count = count_q;
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && !o_full;
  assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for one port of a dual-port RAM.
//   i_clk, i_rst_n             - clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready    - command handshake (write flag, addr, len)
//   i_cmd_write, i_cmd_addr, i_cmd_len - burst type, start address, beats-1
//   i_wdata, i_wvalid/o_wready - write beat stream
//   o_rdata, o_rvalid/i_rready - read beat stream (head of return FIFO)
//   o_ram_en/we/addr/din       - registered RAM port controls
//   i_ram_dout                 - RAM read data, valid RD_LAT edges after sample
//   o_busy, o_done             - burst in progress, one-cycle completion pulse
//   o_state                    - current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready here depends only on
// FSM state (o_cmd_ready, o_wready) or FIFO occupancy (o_rvalid).
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 2,
  parameter int LEN_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output state_t                o_state
);

  localparam int FCW = clog2_depth(FIFO_DEPTH);
  // Holds in_flight + fifo_count, at most RD_LAT+1 + FIFO_DEPTH.
  localparam int CW  = clog2_depth(FIFO_DEPTH + RD_LAT + 1);
  localparam int RW  = LEN_WIDTH + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [RD_LAT:0]       sr_q;
  logic                  ram_en_d, ram_we_d, done_d, issue;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_d;

  logic [CW-1:0]         in_flight;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, credit;

  // sr_q[k] marks a read whose enable was presented k cycles ago; the tail
  // lines up with the edge where i_ram_dout holds that read's data.
  assign push = sr_q[RD_LAT];
  assign pop  = o_rvalid && i_rready;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + CW'(sr_q[i]);
  end

  // Every issued read already owns a FIFO slot, so a push is never dropped.
  assign credit = (in_flight + CW'(fifo_count)) < CW'(FIFO_DEPTH);

  assign o_cmd_ready = (state_q == IDLE) && i_rst_n;
  assign o_wready    = (state_q == WRITE);
  assign o_busy      = (state_q != IDLE);
  assign o_rvalid    = !fifo_empty;
  assign o_state     = state_q;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = o_ram_addr;
    ram_din_d  = o_ram_din;
    done_d     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          cur_d   = i_cmd_addr;
          rem_d   = RW'(i_cmd_len) + RW'(1);
          state_d = (i_cmd_write == OP_WRITE) ? WRITE : READ;
        end
      end
      WRITE: begin
        if (i_wvalid) begin
          ram_en_d   = 1'b1;
          ram_we_d   = OP_WRITE;
          ram_addr_d = cur_q;
          ram_din_d  = i_wdata;
          cur_d      = cur_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - RW'(1);
          if (rem_q == RW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (credit) begin
          issue      = 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = OP_READ;
          ram_addr_d = cur_q;
          cur_d      = cur_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing left in the pipe and the final beat leaves on this edge.
        if (in_flight == '0 && fifo_count == FCW'(1) && pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      sr_q       <= '0;
      o_ram_en   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      sr_q       <= {sr_q[RD_LAT-1:0], issue};
      o_ram_en   <= ram_en_d;
      o_ram_we   <= ram_we_d;
      o_ram_addr <= ram_addr_d;
      o_ram_din  <= ram_din_d;
      o_done     <= done_d;
    end
  end

  ram_burst_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_din   (i_ram_dout),
    .i_pop   (pop),
    .o_dout  (o_rdata),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  a_no_fifo_overflow: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(push && fifo_full)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed bench for ram_burst_master with a behavioural
// RAM model, a read-beat scoreboard and per-cycle RAM port checks.
module tb_ram_burst_master;
  import ram_burst_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int RD_LAT = 2;
  localparam int LW = 4;
  localparam int FIFO_DEPTH = 4;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdata;
  logic          wvalid, wready;
  logic [DW-1:0] rdata;
  logic          rvalid, rready;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, done;
  state_t        st;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] gold [8];
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd_pipe [RD_LAT];

  ram_burst_master #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LAT (RD_LAT),
    .LEN_WIDTH (LW), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_cmd_valid (cmd_valid), .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write), .i_cmd_addr (cmd_addr), .i_cmd_len (cmd_len),
    .i_wdata (wdata), .i_wvalid (wvalid), .o_wready (wready),
    .o_rdata (rdata), .o_rvalid (rvalid), .i_rready (rready),
    .o_ram_en (ram_en), .o_ram_we (ram_we), .o_ram_addr (ram_addr),
    .o_ram_din (ram_din), .i_ram_dout (ram_dout),
    .o_busy (busy), .o_done (done), .o_state (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: read data appears on ram_dout RD_LAT edges after sampling.
  assign ram_dout = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    if (ram_en && !ram_we) rd_pipe[0] <= mem[ram_addr];
    else rd_pipe[0] <= 8'hEE;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  // event counters
  always @(posedge clk) begin
    if (ram_en && !ram_we) rd_cnt <= rd_cnt + 1;
    if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // scoreboard for accepted read beats
  always @(posedge clk) begin
    if (rvalid && rready) begin
      check("rx_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rx_data", rdata, exp_q.pop_front());
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic send_cmd(input logic wr, input int addr, input int len);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready", cmd_ready, 1);
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_busy", busy, 1);
    check("cmd_wready", wready, wr);
    check("cmd_state", st, wr ? WRITE : READ);
    check("cmd_no_early_en", ram_en, 0);
  endtask

  task automatic write_burst(input int addr, input int n, input logic [DW-1:0] d0,
                             input logic [15:0] pat, input int pat_len);
    int sent, cyc, wr0, dn0;
    logic hs;
    sent = 0;
    cyc = 0;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    while (sent < n && cyc < 64) begin
      wvalid = (cyc < pat_len) ? pat[cyc] : 1'b1;
      wdata  = d0 + DW'(sent);
      hs     = wvalid && wready;
      @(negedge clk);
      check("wr_en_we", {ram_en, ram_we}, hs ? 2'b11 : 2'b00);
      if (hs) begin
        check("wr_addr", ram_addr, 32'((addr + sent) % 8));
        check("wr_din", ram_din, wdata);
        gold[(addr + sent) % 8] = wdata;
        sent++;
      end
      check("wr_done", done, 32'(hs && sent == n));
      cyc++;
    end
    wvalid = 1'b0;
    check("wr_beats_sent", sent, n);
    check("wr_idle", busy, 0);
    @(negedge clk);
    check("wr_count", wr_cnt - wr0, n);
    check("wr_done_once", done_cnt - dn0, 1);
  endtask

  task automatic read_burst(input int addr, input int len, input int stall);
    int r0, dn0, t;
    r0 = rd_cnt;
    dn0 = done_cnt;
    for (int i = 0; i <= len; i++) exp_q.push_back(gold[(addr + i) % 8]);
    rready = (stall == 0);
    send_cmd(1'b0, addr, len);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check("rd_credit_stop", rd_cnt - r0, FIFO_DEPTH);
      check("rd_rvalid_stall", rvalid, 1);
      rready = 1'b1;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rd_all_beats", exp_q.size(), 0);
    check("rd_done", done, 1);
    check("rd_busy", busy, 0);
    check("rd_issues", rd_cnt - r0, len + 1);
    @(negedge clk);
    check("rd_done_once", done_cnt - dn0, 1);
  endtask

  initial begin
    int r0, dn0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wdata = '0;
    wvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
      gold[i] = '0;
    end
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_ctl", {ram_en, ram_we}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wready", wready, 0);
    check("rst_state", st, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);

    // write 2..5 then read back
    send_cmd(1'b1, 2, 3);
    write_burst(2, 4, 8'hA1, 16'h0000, 0);
    read_burst(2, 3, 0);

    // write wrapping 6,7,0,1 then read back
    send_cmd(1'b1, 6, 3);
    write_burst(6, 4, 8'hB1, 16'h0000, 0);
    read_burst(6, 3, 0);

    // full-length read with the sink stalled
    read_burst(0, 7, 10);

    // write with gaps 1,0,0,1,0,1
    send_cmd(1'b1, 3, 2);
    write_burst(3, 3, 8'hC1, 16'h0029, 6);

    // reset in the middle of a read
    dn0 = done_cnt;
    rready = 1'b0;
    send_cmd(1'b0, 0, 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ram_en", ram_en, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    repeat (8) @(negedge clk);
    check("post_rst_no_stale", rvalid, 0);
    check("post_rst_no_done", done_cnt - dn0, 0);

    // single-beat read at addr 4
    r0 = rd_cnt;
    dn0 = done_cnt;
    exp_q.push_back(gold[4]);
    send_cmd(1'b0, 4, 0);
    @(negedge clk);
    check("s_en_we", {ram_en, ram_we}, 2'b10);
    check("s_addr", ram_addr, 4);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      check("s_rvalid", rvalid, 32'(k == RD_LAT + 1));
      check("s_ram_idle", ram_en, 0);
    end
    check("s_rdata", rdata, 8'hC2);
    @(negedge clk);
    check("s_done", done, 1);
    check("s_busy", busy, 0);
    check("s_all_beats", exp_q.size(), 0);
    check("s_issues", rd_cnt - r0, 1);
    @(negedge clk);
    check("s_done_once", done_cnt - dn0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Single-clock burst initiator that drives one port of the team's dual-port RAM. It accepts a command (read or write, start address, beat count), streams write beats from a valid/ready source into the RAM, and returns read beats through a valid/ready sink. A credit-managed skid FIFO absorbs the RAM's fixed read latency. One instance sits in front of each RAM port that needs burst access, for example DMA or test-pattern engines.

## Interface
- ADDR_WIDTH, 3, RAM address width; addresses wrap modulo 2**ADDR_WIDTH
- DATA_WIDTH, 8, RAM data width
- RD_LAT, 2, cycles from the edge where the RAM samples a read enable to the edge where i_ram_dout is valid; must be ≥1
- LEN_WIDTH, 4, width of i_cmd_len; beats = i_cmd_len+1 (1..2**LEN_WIDTH)
- FIFO_DEPTH, 4, read-return FIFO entries; must be ≥ RD_LAT+2 for full throughput, ≥1 legal
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_write  in  1  1 = write burst, 0 = read burst
- i_cmd_addr  in  ADDR_WIDTH  start address
- i_cmd_len  in  LEN_WIDTH  beats minus one
- i_wdata  in  DATA_WIDTH  write beat data
- i_wvalid / o_wready  in/out  1  write beat handshake
- o_rdata  out  DATA_WIDTH  read beat data (FIFO head)
- o_rvalid / i_rready  out/in  1  read beat handshake
- o_ram_en, o_ram_we  out  1  RAM port enable / write enable (registered)
- o_ram_addr  out  ADDR_WIDTH  RAM address (registered)
- o_ram_din  out  DATA_WIDTH  RAM write data (registered)
- i_ram_dout  in  DATA_WIDTH  RAM read data
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse at burst completion

## Operation
- FSM states are IDLE, WRITE, READ and DRAIN.
- IDLE:
  - o_cmd_ready=1 when i_rst_n=1.
  - On handshake, latch addr and remaining = len+1, then go to WRITE or READ per i_cmd_write.
- WRITE:
  - o_wready=1.
  - Each accepted beat registers en=1, we=1, addr=cur, din=i_wdata for the next cycle; then cur++ (wrap) and remaining--.
  - When there is no beat, the registered en=0.
  - Last beat accepted → IDLE, with o_done pulsing in the cycle the last RAM write is presented.
- READ:
  - A read issues when credit is available: in_flight + fifo_count < FIFO_DEPTH.
  - An issue registers en=1, we=0, addr=cur.
  - Last issue → DRAIN.
- DRAIN: wait until in_flight=0 and the FIFO is empty with the final beat accepted; then o_done pulses and the FSM goes to IDLE.
- Read capture:
  - An RD_LAT+1 deep valid shift register is tagged at issue.
  - Its tail pushes i_ram_dout into the FIFO.
  - in_flight = popcount of the shift register.
  - The credit rule guarantees a push is never dropped.
- Read output: o_rvalid = FIFO not empty; pop on o_rvalid & i_rready.
- Address: cur increments modulo 2**ADDR_WIDTH; a burst may wrap past the top address.
- Commands are never accepted while o_busy=1; no command queueing.
- Write gaps: i_wvalid low stalls the burst with no timeout.
- Reset at any time:
  - FSM goes to IDLE; FIFO and shift register are cleared, discarding in-flight data.
  - No o_done pulse.
  - A partially written burst is left as-is in the RAM.

## Timing
- Reset values: o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_rvalid, o_rdata, o_busy, o_done and o_wready are all 0. o_cmd_ready is 0 during reset and 1 from the first cycle after release.
- Command latency: handshake at edge N gives o_busy=1 from N+1.
  - Write: o_wready=1 from N+1.
  - Read: first o_ram_en from N+2.
- Read latency: o_ram_en presented in cycle C gives o_rvalid=1 no earlier than cycle C+RD_LAT+1.
- Throughput: 1 beat/cycle in both directions when unstalled and FIFO_DEPTH ≥ RD_LAT+2.
- A RAM write and a RAM read never occur in the same cycle. The RAM port is idle whenever no beat is issued.

## Structure
- Package ram_burst_pkg holds:
  - typedef enum state_t {IDLE, WRITE, READ, DRAIN}
  - OP_READ=0 and OP_WRITE=1 constants
  - a function clog2_depth used to size counters
- Sub-module ram_burst_fifo: synchronous FIFO, parameters DATA_WIDTH and FIFO_DEPTH, push/pop, count, empty/full, same reset. Full is an assertion error, never reached in legal use.

## Test plan
- Write len=3 at addr 2 with data A1,A2,A3,A4 → RAM writes to addrs 2..5; o_done pulses once. A read-back len=3 from addr 2 returns A1..A4 in order.
- Write len=3 at addr 6 → o_ram_addr sequence 6,7,0,1. A read from 6 returns the same four values.
- Read len=7 with i_rready held low for 10 cycles → reads stop after FIFO_DEPTH outstanding. All 8 beats are delivered after release with no loss or duplication.
- Write len=2 with i_wvalid toggling 1,0,0,1,0,1 → exactly 3 RAM writes, each in the cycle after an accepted beat; o_done after the third.
- Reset asserted mid-read, 2 beats in flight → o_rvalid=0 and o_busy=0 after reset, no stale beats, no o_done. A new command is accepted next.
- Single-beat read, len=0 → exactly one o_ram_en, o_rvalid at RD_LAT+1 cycles after it, and o_done on acceptance of that beat.
